alu_arbiter: RTL

Shares one combinational ALU between two requesters, e.g. the main EXE issue path and a branch-compare/address helper. Per cycle it picks at most one request by round-robin, drives the shared ALU operands and control, and captures the result in a single-entry response register with a valid/ready handshake. It also keeps per-requester grant counters for performance monitoring. It sits between the decode/issue logic and the ALU instance in the EXE stage.

---
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Each cycle at most one request is granted, round-robin on contention.
// The granted request's operands go to the ALU, and the ALU result is
// captured in a single-entry response register with a valid/ready handshake.
// Per-requester grant counters are kept for performance monitoring.
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic [3:0]           req0_control,

  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  input  logic [3:0]           req1_control,

  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_control,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_zero,

  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_zero,

  output logic [CNT_WIDTH-1:0] grant_count0,
  output logic [CNT_WIDTH-1:0] grant_count1
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 last_grant_q, last_grant_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]     rsp_result_q, rsp_result_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic [CNT_WIDTH-1:0] grant_count0_q, grant_count0_d;
  logic [CNT_WIDTH-1:0] grant_count1_q, grant_count1_d;

  logic slot_free;
  logic pick0, pick1, pick0_active;
  logic fire0, fire1;

  // Round-robin arbitration: a requester is offered the slot when the other
  // is idle or when the other one won last. Requester 1 additionally yields
  // to an active requester 0 so that at most one grant happens per cycle.
  always_comb begin
    slot_free    = !rsp_valid_q || rsp_ready;
    pick0        = !req1_valid || last_grant_q;
    pick1        = !req0_valid || !last_grant_q;
    pick0_active = req0_valid && pick0;
    req0_ready   = slot_free && pick0;
    req1_ready   = slot_free && pick1 && !pick0_active;
    fire0        = req0_valid && req0_ready;
    fire1        = req1_valid && req1_ready;
  end

  // Steer the granted request onto the shared ALU; idle cycles drive zero so
  // the ALU inputs do not toggle with ungranted traffic.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = 4'd0;
    if (fire0) begin
      alu_a       = req0_a;
      alu_b       = req0_b;
      alu_control = req0_control;
    end else if (fire1) begin
      alu_a       = req1_a;
      alu_b       = req1_b;
      alu_control = req1_control;
    end
  end

  // Next-state: a grant loads a fresh response (replacing any drained one),
  // a drain without a grant just clears valid and keeps the payload.
  always_comb begin
    last_grant_d   = last_grant_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    grant_count0_d = grant_count0_q;
    grant_count1_d = grant_count1_q;
    if (fire0 || fire1) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = fire1;
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
      last_grant_d = fire1;
      if (fire0) begin
        grant_count0_d = grant_count0_q + CNT_ONE;
      end else begin
        grant_count1_d = grant_count1_q + CNT_ONE;
      end
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State register; reset makes requester 0 the winner of the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q   <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      grant_count0_q <= '0;
      grant_count1_q <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      grant_count0_q <= grant_count0_d;
      grant_count1_q <= grant_count1_d;
    end
  end

  // Registered state drives the response and counter outputs directly.
  always_comb begin
    rsp_valid    = rsp_valid_q;
    rsp_id       = rsp_id_q;
    rsp_result   = rsp_result_q;
    rsp_zero     = rsp_zero_q;
    grant_count0 = grant_count0_q;
    grant_count1 = grant_count1_q;
  end

endmodule
